// File: rtl/ram_rd_pkg.sv
// ============================================================================
// ram_rd_pkg : shared state encoding, buffer sizing and count-width helper
// Rev 1.0
// ============================================================================
`default_nettype none

package ram_rd_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DATA_DEPTH = 8;
  localparam int DEF_DATA_ADDR  = 3;

  localparam int BUF_DEPTH = 2;
  localparam int BUF_PTR_W = 1;
  localparam int BUF_CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // burst_len and the remaining counter must represent 0..2*DEPTH-1
  function automatic int cnt_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_burst_reader_if.sv
// ============================================================================
// ram_burst_reader_if : command, RAM read port and output stream bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface ram_burst_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_ADDR  = 3
) ();

  logic                  start;
  logic [DATA_ADDR-1:0]  start_addr;
  logic [DATA_ADDR:0]    burst_len;
  logic                  busy;
  logic                  done;

  logic                  ram_re;
  logic [DATA_ADDR-1:0]  ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_d_out;

  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  m_ready;

  modport master (
    input  start, start_addr, burst_len, ram_d_out, m_ready,
    output busy, done, ram_re, ram_rd_addr, m_valid, m_data, m_last
  );

  modport slave (
    output start, start_addr, burst_len, ram_d_out, m_ready,
    input  busy, done, ram_re, ram_rd_addr, m_valid, m_data, m_last
  );

endinterface

`default_nettype wire

// File: rtl/sync_fifo2.sv
// ============================================================================
// sync_fifo2 : 2-entry synchronous FIFO carrying a data word plus last flag
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_fifo2
  import ram_rd_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH
) (
  input  wire logic             clk,
  input  wire logic             clear,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_push_data,
  input  wire logic             i_push_last,
  input  wire logic             i_pop,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [WIDTH-1:0]      o_head_data,
  output logic                  o_head_last
);

  logic [WIDTH-1:0]     r_data [BUF_DEPTH];
  logic                 r_last [BUF_DEPTH];
  logic [BUF_PTR_W-1:0] r_wr_ptr;
  logic [BUF_PTR_W-1:0] r_rd_ptr;
  logic [BUF_CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full      = (r_count == BUF_CNT_W'(BUF_DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_head_data = r_data[r_rd_ptr];
  assign o_head_last = r_last[r_rd_ptr];

  // A push into a full buffer is only legal when the head leaves in the same cycle
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_data[i] <= '0;
        r_last[i] <= 1'b0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr] <= i_push_data;
        r_last[r_wr_ptr] <= i_push_last;
        r_wr_ptr         <= r_wr_ptr + BUF_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + BUF_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + BUF_CNT_W'(1);
        2'b01:   r_count <= r_count - BUF_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_burst_reader.sv
// ============================================================================
// ram_burst_reader : wrapping sequential RAM burst reader feeding a valid/ready stream
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_burst_reader
  import ram_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DATA_DEPTH = DEF_DATA_DEPTH,
  parameter int DATA_ADDR  = DEF_DATA_ADDR
) (
  input  wire logic          clk,
  input  wire logic          clear,
  ram_burst_reader_if.master bus
);

  localparam int CNT_W = cnt_width(DATA_ADDR);

  state_t               r_state;
  state_t               w_state_next;
  logic [DATA_ADDR-1:0] r_addr;
  logic [CNT_W-1:0]     r_remaining;
  logic                 r_inflight;
  logic                 r_inflight_last;

  logic                  w_full;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_head_last;
  logic                  w_pop;
  logic [1:0]            w_occ;
  logic [2:0]            w_pending;
  logic                  w_accept;
  logic                  w_issue;
  logic                  w_last_issue;
  logic                  w_drained;
  logic [DATA_ADDR-1:0]  w_addr_next;

  assign w_pop     = !w_empty && bus.m_ready;
  assign w_occ     = w_full ? 2'd2 : (w_empty ? 2'd0 : 2'd1);
  // Words that will be buffered or in flight once this cycle's pop has left
  assign w_pending = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};

  assign w_accept     = (r_state == IDLE) && bus.start;
  assign w_issue      = (r_state == READ) && (r_remaining != '0) && (w_pending < 3'd2);
  assign w_last_issue = w_issue && (r_remaining == CNT_W'(1));
  assign w_drained    = !r_inflight && (w_empty || (!w_full && w_pop));
  assign w_addr_next  = (r_addr == DATA_ADDR'(DATA_DEPTH - 1)) ? '0 : r_addr + DATA_ADDR'(1);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = (bus.burst_len == '0) ? DONE : READ;
      READ:    if (w_last_issue) w_state_next = DRAIN;
      DRAIN:   if (w_drained) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state         <= IDLE;
      r_addr          <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_inflight      <= w_issue;
      r_inflight_last <= w_last_issue;
      if (w_accept) begin
        r_addr      <= bus.start_addr;
        r_remaining <= bus.burst_len;
      end else if (w_issue) begin
        r_addr      <= w_addr_next;
        r_remaining <= r_remaining - CNT_W'(1);
      end
    end
  end

  sync_fifo2 #(
    .WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk         (clk),
    .clear       (clear),
    .i_push      (r_inflight),
    .i_push_data (bus.ram_d_out),
    .i_push_last (r_inflight_last),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head_data (w_head_data),
    .o_head_last (w_head_last)
  );

  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = (r_state == DONE);
  assign bus.ram_re      = w_issue;
  assign bus.ram_rd_addr = r_addr;
  assign bus.m_valid     = !w_empty;
  assign bus.m_data      = w_head_data;
  assign bus.m_last      = !w_empty && w_head_last;

endmodule

`default_nettype wire
